// File: rtl/clk_div_gen.sv
// clk_div_gen
//   Derives divided clocks (ratios 1:1 .. 1:8) and matching single-cycle clock
//   enables from forever_cpuclk for the downstream clock aligner/switch stage.
//   All dividers start together after a programmable startup delay and can be
//   re-phase-aligned with div_sync, so every ratio shares a common rising edge.
//
// Ports
//   forever_cpuclk  in   free-running CPU clock (only clock)
//   clkrst_b        in   asynchronous active-low reset
//   div_sync        in   synchronous restart pulse, phase-aligns all dividers
//   clk_div_1       out  forever_cpuclk pass-through (ungated)
//   clk_div_2..8    out  divided clocks, ratio N
//   clk_en_1..8     out  enable for the CPU cycle ending on a clk_div_N rise
//   div_running     out  high once the startup delay has elapsed (sticky)
//
// Parameters
//   RST_RELEASE_DLY  edges after reset release before dividers start (0..15)
//
// Optional build macro
//   CLK_DIV_ODD_50DUTY_EN  adds a negedge flop per odd ratio (3, 5, 7) so those
//                          clocks get exactly 50% duty; even ratios unchanged.
module clk_div_gen #(
  parameter int RST_RELEASE_DLY = 2
) (
  input  logic forever_cpuclk,
  input  logic clkrst_b,
  input  logic div_sync,
  output logic clk_div_1,
  output logic clk_div_2,
  output logic clk_div_3,
  output logic clk_div_4,
  output logic clk_div_5,
  output logic clk_div_6,
  output logic clk_div_7,
  output logic clk_div_8,
  output logic clk_en_1,
  output logic clk_en_2,
  output logic clk_en_3,
  output logic clk_en_4,
  output logic clk_en_5,
  output logic clk_en_6,
  output logic clk_en_7,
  output logic clk_en_8,
  output logic div_running
);

  localparam logic [3:0] DLY = 4'(RST_RELEASE_DLY);

  logic [3:0] start_cnt;
  logic       run_q;
  logic       run_next;
  logic       sync_hit;
  logic       en1_q;

  // run_q rises on the (DLY+1)-th edge after release and then stays set.
  assign run_next = run_q | (start_cnt == DLY);
  // div_sync only counts once the dividers are running.
  assign sync_hit = run_q & div_sync;

  // Startup delay
  always_ff @(posedge forever_cpuclk or negedge clkrst_b) begin
    if (!clkrst_b) begin
      start_cnt <= 4'd0;
      run_q     <= 1'b0;
      en1_q     <= 1'b0;
    end else begin
      run_q <= run_next;
      en1_q <= run_next;
      if (!run_next) start_cnt <= start_cnt + 4'd1;
    end
  end

  // Per-ratio dividers
  for (genvar n = 2; n <= 8; n++) begin : g_div
    localparam logic [2:0] LAST = 3'(n - 1);
    localparam logic [2:0] HALF = 3'(n / 2);

    logic [2:0] cnt_q;
    logic [2:0] cnt_nxt;
    logic       div_q;
    logic       en_q;
    logic       div_out;

    // Sync parks every counter on its last phase, so all wrap to 0 together.
    always_comb begin
      cnt_nxt = cnt_q;
      if (sync_hit)   cnt_nxt = LAST;
      else if (run_q) cnt_nxt = (cnt_q == LAST) ? 3'd0 : cnt_q + 3'd1;
    end

    always_ff @(posedge forever_cpuclk or negedge clkrst_b) begin
      if (!clkrst_b) begin
        cnt_q <= LAST;
        div_q <= 1'b0;
        en_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_nxt;
        div_q <= run_q & (cnt_nxt < HALF);
        en_q  <= run_next & (cnt_nxt == LAST);
      end
    end

`ifdef CLK_DIV_ODD_50DUTY_EN
    if (n % 2 == 1) begin : g_odd
      logic div_nq;

      // Half-cycle delayed copy stretches the high phase to exactly N/2.
      always_ff @(negedge forever_cpuclk or negedge clkrst_b) begin
        if (!clkrst_b) div_nq <= 1'b0;
        else           div_nq <= div_q;
      end

      assign div_out = div_q | div_nq;
    end else begin : g_even
      assign div_out = div_q;
    end
`else
    assign div_out = div_q;
`endif
  end

  assign clk_div_1   = forever_cpuclk;
  assign clk_div_2   = g_div[2].div_out;
  assign clk_div_3   = g_div[3].div_out;
  assign clk_div_4   = g_div[4].div_out;
  assign clk_div_5   = g_div[5].div_out;
  assign clk_div_6   = g_div[6].div_out;
  assign clk_div_7   = g_div[7].div_out;
  assign clk_div_8   = g_div[8].div_out;

  assign clk_en_1    = en1_q;
  assign clk_en_2    = g_div[2].en_q;
  assign clk_en_3    = g_div[3].en_q;
  assign clk_en_4    = g_div[4].en_q;
  assign clk_en_5    = g_div[5].en_q;
  assign clk_en_6    = g_div[6].en_q;
  assign clk_en_7    = g_div[7].en_q;
  assign clk_en_8    = g_div[8].en_q;

  assign div_running = run_q;

endmodule

// File: tb/tb_clk_div_gen.sv
module tb_clk_div_gen;

  logic forever_cpuclk = 1'b0;
  logic clkrst_b = 1'b0;
  logic div_sync = 1'b0;
  logic clk_div_1, clk_div_2, clk_div_3, clk_div_4;
  logic clk_div_5, clk_div_6, clk_div_7, clk_div_8;
  logic clk_en_1, clk_en_2, clk_en_3, clk_en_4;
  logic clk_en_5, clk_en_6, clk_en_7, clk_en_8;
  logic div_running;

  logic [6:0] div_v;
  logic [7:0] en_v;

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic       rst_b;
    logic       sync;
    logic [6:0] div;   // {div8 .. div2}
    logic [7:0] en;    // {en8 .. en1}
    logic       run;
  } vec_t;

`ifdef CLK_DIV_ODD_50DUTY_EN
  // Odd-ratio clocks carry a half-cycle tail in this build; the table only
  // holds the posedge-register values, so odd bits are excluded there.
  localparam logic [6:0] TBL_MASK = 7'b1010101;
`else
  localparam logic [6:0] TBL_MASK = 7'b1111111;
`endif

  clk_div_gen #(.RST_RELEASE_DLY(2)) dut (
    .forever_cpuclk (forever_cpuclk),
    .clkrst_b       (clkrst_b),
    .div_sync       (div_sync),
    .clk_div_1      (clk_div_1),
    .clk_div_2      (clk_div_2),
    .clk_div_3      (clk_div_3),
    .clk_div_4      (clk_div_4),
    .clk_div_5      (clk_div_5),
    .clk_div_6      (clk_div_6),
    .clk_div_7      (clk_div_7),
    .clk_div_8      (clk_div_8),
    .clk_en_1       (clk_en_1),
    .clk_en_2       (clk_en_2),
    .clk_en_3       (clk_en_3),
    .clk_en_4       (clk_en_4),
    .clk_en_5       (clk_en_5),
    .clk_en_6       (clk_en_6),
    .clk_en_7       (clk_en_7),
    .clk_en_8       (clk_en_8),
    .div_running    (div_running)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  assign div_v = {clk_div_8, clk_div_7, clk_div_6, clk_div_5, clk_div_4, clk_div_3, clk_div_2};
  assign en_v  = {clk_en_8, clk_en_7, clk_en_6, clk_en_5, clk_en_4, clk_en_3, clk_en_2, clk_en_1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: sample point is 2 time units after the rising edge.
  task automatic step();
    @(posedge forever_cpuclk);
    #2;
  endtask

  // k = edges after the common rising edge (k = 0 at the rise).
  function automatic logic [6:0] exp_div(input int k);
    logic [6:0] r;
    r = '0;
    for (int n = 2; n <= 8; n++) begin
`ifdef CLK_DIV_ODD_50DUTY_EN
      if (n % 2 == 1) r[n-2] = (k % n) <= (n / 2);
      else            r[n-2] = (k % n) < (n / 2);
`else
      r[n-2] = (k % n) < (n / 2);
`endif
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_en(input int k);
    logic [7:0] r;
    r = 8'h01;
    for (int n = 2; n <= 8; n++) r[n-1] = (k % n) == (n - 1);
    return r;
  endfunction

  initial begin
    vec_t vecs[$];
    int   k;
    int   en8_cnt;

    // rst_b sync  div    en     run
    for (int i = 0; i < 5; i++) vecs.push_back(vec_t'{1'b0, 1'b0, 7'h00, 8'h00, 1'b0});
    // startup, div_sync ignored while not running
    vecs.push_back(vec_t'{1'b1, 1'b1, 7'h00, 8'h00, 1'b0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 7'h00, 8'h00, 1'b0});
    vecs.push_back(vec_t'{1'b1, 1'b1, 7'h00, 8'hFF, 1'b1});
    // common rise, then phases 1..4
    vecs.push_back(vec_t'{1'b1, 1'b0, 7'h7F, 8'h01, 1'b1});
    vecs.push_back(vec_t'{1'b1, 1'b0, 7'h7C, 8'h03, 1'b1});
    vecs.push_back(vec_t'{1'b1, 1'b0, 7'h71, 8'h05, 1'b1});
    vecs.push_back(vec_t'{1'b1, 1'b0, 7'h42, 8'h0B, 1'b1});
    vecs.push_back(vec_t'{1'b1, 1'b0, 7'h05, 8'h11, 1'b1});
    // single-cycle sync
    vecs.push_back(vec_t'{1'b1, 1'b1, 7'h00, 8'hFF, 1'b1});
    vecs.push_back(vec_t'{1'b1, 1'b0, 7'h7F, 8'h01, 1'b1});
    vecs.push_back(vec_t'{1'b1, 1'b0, 7'h7C, 8'h03, 1'b1});
    // sync held three cycles
    vecs.push_back(vec_t'{1'b1, 1'b1, 7'h00, 8'hFF, 1'b1});
    vecs.push_back(vec_t'{1'b1, 1'b1, 7'h00, 8'hFF, 1'b1});
    vecs.push_back(vec_t'{1'b1, 1'b1, 7'h00, 8'hFF, 1'b1});
    vecs.push_back(vec_t'{1'b1, 1'b0, 7'h7F, 8'h01, 1'b1});
    vecs.push_back(vec_t'{1'b1, 1'b0, 7'h7C, 8'h03, 1'b1});
    vecs.push_back(vec_t'{1'b1, 1'b0, 7'h71, 8'h05, 1'b1});

    for (int i = 0; i < vecs.size(); i++) begin
      clkrst_b = vecs[i].rst_b;
      div_sync = vecs[i].sync;
      step();
      chk($sformatf("vec%0d_div", i), 32'(div_v & TBL_MASK), 32'(vecs[i].div & TBL_MASK));
      chk($sformatf("vec%0d_en", i), 32'(en_v), 32'(vecs[i].en));
      chk($sformatf("vec%0d_run", i), 32'(div_running), 32'(vecs[i].run));
    end

    // Free run, 48 cycles, continuing from phase 2
    div_sync = 1'b0;
    k = 2;
    en8_cnt = 0;
    for (int c = 0; c < 48; c++) begin
      k++;
      step();
      chk($sformatf("run_div_k%0d", k), 32'(div_v), 32'(exp_div(k)));
      chk($sformatf("run_en_k%0d", k), 32'(en_v), 32'(exp_en(k)));
      if (clk_en_8) en8_cnt++;
    end
    chk("en8_count_48", 32'(en8_cnt), 32'd6);

    // Move to a phase where clk_div_6 is high, then reset asynchronously
    for (int c = 0; c < 6 && (k % 6) != 0; c++) begin
      k++;
      step();
    end
    chk("div6_high_before_rst", 32'(clk_div_6), 32'd1);
    clkrst_b = 1'b0;
    #1;
    chk("async_rst_div6", 32'(clk_div_6), 32'd0);
    chk("async_rst_en6", 32'(clk_en_6), 32'd0);
    chk("async_rst_div", 32'(div_v), 32'd0);
    chk("async_rst_en", 32'(en_v), 32'd0);
    chk("async_rst_run", 32'(div_running), 32'd0);
    step();
    chk("div1_high_in_rst", 32'(clk_div_1), 32'd1);
    @(negedge forever_cpuclk);
    #1;
    chk("div1_low_in_rst", 32'(clk_div_1), 32'd0);
    step();
    clkrst_b = 1'b1;
    step();
    chk("restart_e1_run", 32'(div_running), 32'd0);
    chk("restart_e1_en", 32'(en_v), 32'd0);
    step();
    chk("restart_e2_run", 32'(div_running), 32'd0);
    chk("restart_e2_div", 32'(div_v), 32'd0);
    step();
    chk("restart_e3_run", 32'(div_running), 32'd1);
    chk("restart_e3_en", 32'(en_v), 32'hFF);
    chk("restart_e3_div", 32'(div_v), 32'd0);
    step();
    chk("restart_e4_div", 32'(div_v), 32'h7F);
    chk("restart_e4_en", 32'(en_v), 32'h01);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
